opr_sequencer: RTL and testbench
================================

Name: opr_sequencer

Overview:
- Multi-cycle controller that executes PDP-8 operate (OPR, opcode 7) microinstructions one micro-event per clock, in architectural order.
- Sits between the major-state controller and the AC/L/PC registers.
- Captures the instruction, AC, L and switch register on start.
- Steps through only the enabled phases.
- On completion, pulses done with a new AC/L, plus skip and halt requests.

Parameters:
- WORD_WIDTH, 12, width of AC, SR and result (link is always 1 bit).

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin executing i_reg; sampled only in IDLE
- i_reg  input  9  low 9 bits of the OPR instruction (bit 8 = group select)
- ac_in  input  WORD_WIDTH  current accumulator, captured on start
- l_in  input  1  current link, captured on start
- sr  input  WORD_WIDTH  front-panel switch register, sampled in OSR phase
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle completion pulse
- ac_out  output  WORD_WIDTH  result accumulator; valid with done, held until next start
- l_out  output  1  result link; valid with done, held
- ac_we  output  1  pulses with done when the instruction is group 1 or group 2
- pc_skip  output  1  pulses with done when the group 2 skip condition is true
- halt  output  1  pulses with done when group 2 HLT (bit 1) is set
- g3_unimpl  output  1  pulses with done for group 3 (i_reg[8]=1, i_reg[0]=1)

Behaviour:
- **Reset:** state=IDLE; busy, done, ac_we, pc_skip, halt and g3_unimpl are 0; ac_out=0; l_out=0.
  - Reset mid-operation aborts immediately.
  - No done or write pulses follow an aborted instruction.
- **Start:** start in IDLE (cycle T) latches i_reg, ac_in and l_in into working registers.
  - start outside IDLE is ignored.
- **Group decode:** i_reg[8]=0 is group 1; i_reg[8]=1 with i_reg[0]=0 is group 2; i_reg[8]=1 with i_reg[0]=1 is group 3.
- **Group 1 phases, in order, each only if enabled, one cycle each:**
  - CLEAR: bit7 CLA sets AC=0; bit6 CLL sets L=0.
  - COMPLEMENT: bit5 CMA sets AC=~AC; bit4 CML sets L=~L.
  - INCREMENT: bit0 IAC; the 13-bit {L,AC}+1 wraps, so 1_7777 becomes 0_0000.
  - ROTATE, selected by bits 3,2,1 (RAR, RAL, BSW):
    - 001 = byte swap, 1 cycle; L unchanged.
    - 010 = RAL, 1 cycle.
    - 011 = RTL, 2 cycles, one 13-bit left rotate per cycle.
    - 100 = RAR, 1 cycle.
    - 101 = RTR, 2 cycles.
    - All other codes, including RAR+RAL together, have no rotate phase.
- **Group 2 phases:**
  - SKIP_EVAL always runs and uses the latched AC/L before CLA.
    - bit3=0 (OR group): skip = (SMA & AC[11]) | (SZA & AC==0) | (SNL & L).
    - bit3=1 (AND group): skip = (SPA ? !AC[11] : 1) & (SNA ? AC!=0 : 1) & (SZL ? !L : 1). With no conditions set this is an unconditional skip.
  - CLEAR: runs if bit7 is set.
  - OSR: runs if bit2 is set; AC |= sr, with sr sampled in that cycle.
  - HLT: bit1 sets the halt flag; it takes no phase cycle.
- **Group 3:** no phases; AC/L unchanged; ac_we=0; g3_unimpl pulses.
- **Latency:** with N enabled phase cycles, done is asserted at cycle T+N+1 (DONE state), then the block returns to IDLE.
  - A group 1 instruction with no bits set (NOP) gives N=0, so done is at T+1.
  - A new start is accepted at the earliest in the cycle after done.
- **Outputs:** ac_out/l_out update only in the DONE cycle. done, ac_we, pc_skip, halt and g3_unimpl are single-cycle pulses, coincident with each other.

Test Plan:
- 7240 (CLA CMA), AC=1234, L=1, start at T -> done at T+3, ac_out=7777, l_out=1, ac_we=1, pc_skip=0.
- 7001 (IAC), AC=7777, L=0 -> done at T+2, ac_out=0000, l_out=1.
- 7012 (RTR), AC=0001, L=0 -> done at T+3, ac_out=4000, l_out=0; mid-state after the first rotate has L=1, AC=0000. Separately, 7002 (BSW) with AC=0077 -> done at T+2, ac_out=7700.
- Group 2 skip cases:
  - 7500 (SMA), AC=4000 -> done at T+2, pc_skip=1, ac_out=4000.
  - 7510 (SPA), AC=4000 -> pc_skip=0.
  - 7410 (SKP) -> pc_skip=1.
  - 7640 (SZA CLA), AC=0000 -> pc_skip=1, ac_out=0000.
- 7604 (CLA OSR), AC=1111, sr=5252 -> done at T+4, ac_out=5252. Separately, 7402 (HLT) -> halt=1 and ac_we=1 with AC unchanged.
- Reset asserted at T+1 of 7012 -> no done, busy=0 next cycle, ac_out=0. Then:
  - start at T+1 of 7001 (busy) is ignored, no second done.
  - 7401 (group 3) -> g3_unimpl=1, ac_we=0, done at T+1.

Source files
------------

// File: rtl/opr_sequencer.sv
// PDP-8 operate (OPR) microinstruction sequencer: executes one enabled
// micro-event per clock in architectural order, then pulses done with the new AC/L.
module opr_sequencer #(
    parameter int WORD_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8:0]            i_reg,
    input  logic [WORD_WIDTH-1:0] ac_in,
    input  logic                  l_in,
    input  logic [WORD_WIDTH-1:0] sr,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] ac_out,
    output logic                  l_out,
    output logic                  ac_we,
    output logic                  pc_skip,
    output logic                  halt,
    output logic                  g3_unimpl
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_CMPL,
        S_INCR,
        S_ROT1,
        S_ROT2,
        S_SKIP,
        S_OSR,
        S_DONE
    } state_t;

    localparam int HALF = WORD_WIDTH / 2;
    localparam logic [WORD_WIDTH:0] LINK_AC_ONE = (WORD_WIDTH + 1)'(1);

    state_t                state;
    state_t                state_next;
    logic [8:0]            ir_q;
    logic [WORD_WIDTH-1:0] ac_q;
    logic                  l_q;
    logic                  skip_q;
    logic [WORD_WIDTH-1:0] ac_hold;
    logic                  l_hold;
    logic                  skip_eval;
    logic                  ac_msb;
    logic                  ac_zero;
    logic                  is_group2;
    logic                  is_group3;

    // Returns the next enabled phase after 'cur' for instruction 'ir'.
    // Disabled phases are skipped entirely; no enabled phase left means DONE.
    function automatic state_t next_phase(input logic [8:0] ir, input state_t cur);
        logic [2:0] rot;
        logic       rot_en;
        logic       rot_two;
        rot        = ir[3:1];
        rot_en     = rot inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        rot_two    = rot inside {3'b011, 3'b101};
        next_phase = S_DONE;
        if (!ir[8]) begin
            if (cur == S_IDLE && (ir[7] || ir[6]))
                next_phase = S_CLEAR;
            else if ((cur inside {S_IDLE, S_CLEAR}) && (ir[5] || ir[4]))
                next_phase = S_CMPL;
            else if ((cur inside {S_IDLE, S_CLEAR, S_CMPL}) && ir[0])
                next_phase = S_INCR;
            else if ((cur inside {S_IDLE, S_CLEAR, S_CMPL, S_INCR}) && rot_en)
                next_phase = S_ROT1;
            else if (cur == S_ROT1 && rot_two)
                next_phase = S_ROT2;
        end else if (!ir[0]) begin
            // Group 2 evaluates the skip first so it sees AC/L before CLA.
            if (cur == S_IDLE)
                next_phase = S_SKIP;
            else if (cur == S_SKIP && ir[7])
                next_phase = S_CLEAR;
            else if ((cur inside {S_SKIP, S_CLEAR}) && ir[2])
                next_phase = S_OSR;
        end
    endfunction

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = next_phase(i_reg, S_IDLE);
            S_DONE:  state_next = S_IDLE;
            default: state_next = next_phase(ir_q, state);
        endcase
    end

    always_comb begin
        ac_msb    = ac_q[WORD_WIDTH-1];
        ac_zero   = (ac_q == '0);
        skip_eval = ir_q[3]
            ? ((!ir_q[6] || !ac_msb) && (!ir_q[5] || !ac_zero) && (!ir_q[4] || !l_q))
            : ((ir_q[6] && ac_msb) || (ir_q[5] && ac_zero) || (ir_q[4] && l_q));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ir_q    <= '0;
            ac_q    <= '0;
            l_q     <= 1'b0;
            skip_q  <= 1'b0;
            ac_hold <= '0;
            l_hold  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ir_q   <= i_reg;
                        ac_q   <= ac_in;
                        l_q    <= l_in;
                        skip_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (ir_q[8]) begin
                        ac_q <= '0;
                    end else begin
                        if (ir_q[7]) ac_q <= '0;
                        if (ir_q[6]) l_q  <= 1'b0;
                    end
                end
                S_CMPL: begin
                    if (ir_q[5]) ac_q <= ~ac_q;
                    if (ir_q[4]) l_q  <= ~l_q;
                end
                S_INCR: {l_q, ac_q} <= {l_q, ac_q} + LINK_AC_ONE;
                S_ROT1, S_ROT2: begin
                    case (ir_q[3:1])
                        3'b001:         ac_q        <= {ac_q[HALF-1:0], ac_q[WORD_WIDTH-1:HALF]};
                        3'b010, 3'b011: {l_q, ac_q} <= {ac_q, l_q};
                        3'b100, 3'b101: {l_q, ac_q} <= {ac_q[0], l_q, ac_q[WORD_WIDTH-1:1]};
                        default:        ;
                    endcase
                end
                S_SKIP:  skip_q <= skip_eval;
                S_OSR:   ac_q   <= ac_q | sr;
                S_DONE: begin
                    ac_hold <= ac_q;
                    l_hold  <= l_q;
                end
                default: ;
            endcase
        end
    end

    assign is_group2 = ir_q[8] && !ir_q[0];
    assign is_group3 = ir_q[8] && ir_q[0];

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        ac_out    = ac_hold;
        l_out     = l_hold;
        ac_we     = 1'b0;
        pc_skip   = 1'b0;
        halt      = 1'b0;
        g3_unimpl = 1'b0;
        if (state != S_IDLE) busy = 1'b1;
        if (state == S_DONE) begin
            done      = 1'b1;
            ac_out    = ac_q;
            l_out     = l_q;
            ac_we     = !is_group3;
            pc_skip   = skip_q;
            halt      = is_group2 && ir_q[1];
            g3_unimpl = is_group3;
        end
    end

endmodule

// File: tb/tb_opr_sequencer.sv
// Directed bench for opr_sequencer: table of OPR vectors with hand-computed
// results and latencies, plus hand sequences for mid-rotate, abort and busy-start.
module tb_opr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  i_reg;
    logic [11:0] ac_in;
    logic        l_in;
    logic [11:0] sr;
    logic        busy;
    logic        done;
    logic [11:0] ac_out;
    logic        l_out;
    logic        ac_we;
    logic        pc_skip;
    logic        halt;
    logic        g3_unimpl;

    int checks   = 0;
    int failures = 0;

    opr_sequencer #(.WORD_WIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .i_reg     (i_reg),
        .ac_in     (ac_in),
        .l_in      (l_in),
        .sr        (sr),
        .busy      (busy),
        .done      (done),
        .ac_out    (ac_out),
        .l_out     (l_out),
        .ac_we     (ac_we),
        .pc_skip   (pc_skip),
        .halt      (halt),
        .g3_unimpl (g3_unimpl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ir;
        logic [11:0] ac;
        logic        l;
        logic [11:0] s;
        int          lat;   // done expected this many cycles after the start cycle
        logic [11:0] exp_ac;
        logic        exp_l;
        logic        exp_we;
        logic        exp_skip;
        logic        exp_halt;
        logic        exp_g3;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %o expected %o", name, act, exp);
        end
    endtask

    // Drives one instruction from a falling edge and follows it to completion.
    task automatic apply(input vec_t v, input int idx);
        int    cyc;
        string tag;
        tag   = $sformatf("v%0d_%03o", idx, v.ir);
        i_reg = v.ir;
        ac_in = v.ac;
        l_in  = v.l;
        sr    = v.s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy"}, busy, 1);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, v.lat);
        check({tag, "_done"}, done, 1);
        check({tag, "_ac"}, ac_out, v.exp_ac);
        check({tag, "_l"}, l_out, v.exp_l);
        check({tag, "_we"}, ac_we, v.exp_we);
        check({tag, "_skip"}, pc_skip, v.exp_skip);
        check({tag, "_halt"}, halt, v.exp_halt);
        check({tag, "_g3"}, g3_unimpl, v.exp_g3);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_ac_held"}, ac_out, v.exp_ac);
    endtask

    initial begin
        int dones;

        //             ir      ac       l  sr       lat ac_out  l  we skp hlt g3
        vecs[0]  = '{9'o240, 12'o1234, 1, 12'o0000, 3, 12'o7777, 1, 1, 0, 0, 0}; // CLA CMA
        vecs[1]  = '{9'o001, 12'o7777, 0, 12'o0000, 2, 12'o0000, 1, 1, 0, 0, 0}; // IAC wraps into L
        vecs[2]  = '{9'o012, 12'o0001, 0, 12'o0000, 3, 12'o4000, 0, 1, 0, 0, 0}; // RTR
        vecs[3]  = '{9'o002, 12'o0077, 0, 12'o0000, 2, 12'o7700, 0, 1, 0, 0, 0}; // BSW
        vecs[4]  = '{9'o000, 12'o1234, 1, 12'o0000, 1, 12'o1234, 1, 1, 0, 0, 0}; // NOP
        vecs[5]  = '{9'o004, 12'o4000, 0, 12'o0000, 2, 12'o0000, 1, 1, 0, 0, 0}; // RAL
        vecs[6]  = '{9'o006, 12'o2000, 0, 12'o0000, 3, 12'o0000, 1, 1, 0, 0, 0}; // RTL
        vecs[7]  = '{9'o010, 12'o0001, 0, 12'o0000, 2, 12'o0000, 1, 1, 0, 0, 0}; // RAR
        vecs[8]  = '{9'o120, 12'o1234, 1, 12'o0000, 3, 12'o1234, 1, 1, 0, 0, 0}; // CLL CML
        vecs[9]  = '{9'o016, 12'o1234, 0, 12'o0000, 1, 12'o1234, 0, 1, 0, 0, 0}; // RAR+RAL: no rotate
        vecs[10] = '{9'o005, 12'o3777, 0, 12'o0000, 3, 12'o0000, 1, 1, 0, 0, 0}; // IAC RAL
        vecs[11] = '{9'o500, 12'o4000, 0, 12'o0000, 2, 12'o4000, 0, 1, 1, 0, 0}; // SMA
        vecs[12] = '{9'o510, 12'o4000, 0, 12'o0000, 2, 12'o4000, 0, 1, 0, 0, 0}; // SPA
        vecs[13] = '{9'o410, 12'o1234, 0, 12'o0000, 2, 12'o1234, 0, 1, 1, 0, 0}; // SKP
        vecs[14] = '{9'o640, 12'o0000, 0, 12'o0000, 3, 12'o0000, 0, 1, 1, 0, 0}; // SZA CLA
        vecs[15] = '{9'o460, 12'o0001, 1, 12'o0000, 2, 12'o0001, 1, 1, 1, 0, 0}; // SZA SNL (OR)
        vecs[16] = '{9'o470, 12'o0001, 1, 12'o0000, 2, 12'o0001, 1, 1, 0, 0, 0}; // SNA SZL (AND)
        vecs[17] = '{9'o604, 12'o1111, 0, 12'o5252, 4, 12'o5252, 0, 1, 0, 0, 0}; // CLA OSR
        vecs[18] = '{9'o402, 12'o2525, 1, 12'o0000, 2, 12'o2525, 1, 1, 0, 1, 0}; // HLT
        vecs[19] = '{9'o401, 12'o1357, 1, 12'o0000, 1, 12'o1357, 1, 0, 0, 0, 1}; // group 3

        reset = 1'b1;
        start = 1'b0;
        i_reg = '0;
        ac_in = '0;
        l_in  = 1'b0;
        sr    = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ac", ac_out, 0);
        check("rst_l", l_out, 0);
        check("rst_we", ac_we, 0);
        check("rst_skip", pc_skip, 0);
        check("rst_halt", halt, 0);
        check("rst_g3", g3_unimpl, 0);
        reset = 1'b0;
        @(negedge clk);

        // Each vector starts in the cycle right after the previous done.
        for (int i = 0; i < 20; i++) apply(vecs[i], i);

        // RTR mid-state: after the first right rotate L=1, AC=0000.
        i_reg = 9'o012;
        ac_in = 12'o0001;
        l_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rtr_mid_l", dut.l_q, 1);
        check("rtr_mid_ac", dut.ac_q, 0);
        check("rtr_mid_done", done, 0);
        check("rtr_mid_ac_out_held", ac_out, 12'o1357);
        @(negedge clk);
        check("rtr_end_done", done, 1);
        check("rtr_end_ac", ac_out, 12'o4000);
        @(negedge clk);

        // Abort: reset during the first rotate of RTR.
        i_reg = 9'o012;
        ac_in = 12'o0001;
        l_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ac", ac_out, 0);
        check("abort_we", ac_we, 0);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // start held into the busy cycle must not launch a second instruction.
        i_reg = 9'o001;
        ac_in = 12'o0005;
        l_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("busy_start_busy", busy, 1);
        dones = 0;
        @(negedge clk);
        start = 1'b0;
        if (done) begin
            dones++;
            check("busy_start_ac", ac_out, 12'o0006);
        end
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("busy_start_one_done", dones, 1);
        check("busy_start_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
